keyboard_decoder: RTL
=====================

Name: keyboard_decoder

Overview:
PS/2 keyboard front end. It deserialises raw PS/2 frames, translates scancodes into the 3-bit game operation code, and acts as the producer side of the keyboard_ready / keyboard_data / keyboard_read_fin handshake consumed by the game logic. It sits between the board PS/2 pins and the game-player block, in the same clock domain as the game logic.

Parameters:
TIMEOUT_CYCLES, 50000, clock cycles with no PS/2 falling edge before a partial frame is discarded
LOG2_TIMEOUT, 16, width of the timeout counter

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ps2_clock  input  1  raw PS/2 clock pin; asynchronous
ps2_data  input  1  raw PS/2 data pin; asynchronous
keyboard_read_fin  input  1  consumer acknowledge; 1 = data taken
keyboard_ready  output  1  1 = keyboard_data holds an unconsumed operation
keyboard_data  output  3  operation code: W=000, A=001, S=010, D=011, SPACE=100, Z=101
frame_error  output  1  one-cycle pulse on a parity, stop-bit or timeout error
drop_count  output  8  saturating count of operations lost to buffer overflow

Behaviour:
- Reset (reset=0, asynchronous): all FSMs return to idle. keyboard_ready=0, keyboard_data=3'b110 (NONE), frame_error=0, drop_count=0. Prefix flags and the buffer are cleared. Reset mid-frame or mid-handshake abandons the frame or handshake silently.
- Input conditioning: 2-FF synchroniser on ps2_clock and ps2_data. A falling edge is sync'd ps2_clock changing from 1 to 0, and is detected 3 clock cycles after the pin edge. Data is sampled on the detect cycle.
- Frame receive FSM:
  - IDLE: on an edge with data=0 (start bit) go to DATA, bit_cnt=0. An edge with data=1 is ignored.
  - DATA: 8 bits, LSB first, then go to PARITY.
  - PARITY: go to STOP.
  - STOP: valid only if odd parity holds (data bits + parity has an odd number of 1s) and the stop bit is 1. Valid: byte_valid pulses for 1 cycle on the cycle after the stop edge. Invalid: frame_error pulses for 1 cycle and the byte is discarded. Either way return to IDLE.
- Timeout: the counter resets on every edge. In any state other than IDLE, reaching TIMEOUT_CYCLES-1 gives: frame_error pulse, return to IDLE, prefix flags cleared.
- Scancode decoder (acts on byte_valid):
  - 0xE0 sets ext; 0xF0 sets brk. No output for either.
  - Any other byte produces an op only if brk=0, then clears both flags.
  - Non-extended map: 0x1D→W, 0x1C→A, 0x1B→S, 0x23→D, 0x29→SPACE, 0x1A→Z.
  - Extended map (ext=1): 0x75→W, 0x6B→A, 0x72→S, 0x74→D.
  - Unmapped codes produce no op but still clear the flags. A frame error also clears both flags.
  - Typematic repeat makes each produce an op. Break codes never produce one.
- Handshake FSM (4-phase):
  - H_IDLE: when an op is available (from the buffer first, else from the decoder), latch keyboard_data, drive keyboard_ready=1, go to H_READY. The op appears on the cycle after byte_valid.
  - H_READY: hold keyboard_data stable. When keyboard_read_fin=1, drop keyboard_ready to 0 on the next edge and go to H_WAIT.
  - H_WAIT: when keyboard_read_fin=0, go to H_IDLE. The next op may assert ready no earlier than the cycle after that.
- Buffer: 1 entry.
  - An op decoded while not in H_IDLE goes to the buffer if it is empty.
  - If the buffer is full, the new op is dropped and drop_count increments (saturates at 255).
  - A decode in the same cycle the buffer drains into H_IDLE: the buffered op goes out first and the new op takes the freed entry, so nothing is lost.
- keyboard_data holds its last value while keyboard_ready=0.

Decomposition:
- Shared package generals_pkg holds:
  - the Operation enum (W, A, S, D, SPACE, Z, NONE, with the encodings above)
  - scancode constants SC_W, SC_A, SC_S, SC_D, SC_SPACE, SC_Z, SC_EXT=0xE0, SC_BREAK=0xF0, SC_UP, SC_LEFT, SC_DOWN, SC_RIGHT
- The game-player block imports the same enum.
- One sub-module, ps2_frame_receiver: synchroniser, edge detect, frame FSM and timeout. Outputs byte, byte_valid and frame_error.
- Scancode decode, buffer and handshake stay in keyboard_decoder.

Test Plan:
- Reset release, then frame 0x1D with correct parity; bench acks fin one cycle after ready → keyboard_data=000, ready=1 then 0 after fin; exactly one handshake.
- Frames E0 75, then F0 1D → one op W (000) from the arrow key; the break sequence produces nothing and ready stays 0.
- Frame 0x29 with wrong parity bit → frame_error pulses once, no ready. A following valid 0x1A → data=101.
- Start bit plus 4 data bits, then silence for TIMEOUT_CYCLES → frame_error pulse, FSM back to IDLE. The next full 0x1C frame decodes to 001.
- Bench withholds fin; send 0x1D, 0x1C, 0x1B → ready held with 000, drop_count=1. After fin 1→0 the next handshake delivers 001; 0x1B is never delivered.
- Assert reset mid-frame (after 5 bits) and mid-handshake (ready=1) → outputs return to the reset values immediately, with no spurious op after release.

Source files
------------

// File: rtl/generals_pkg.sv
// Shared types for the keyboard front end and the game logic: operation codes,
// PS/2 scancodes and the internal FSM state encodings.
package generals_pkg;

  typedef enum logic [2:0] {
    OP_W     = 3'b000,
    OP_A     = 3'b001,
    OP_S     = 3'b010,
    OP_D     = 3'b011,
    OP_SPACE = 3'b100,
    OP_Z     = 3'b101,
    OP_NONE  = 3'b110
  } operation_t;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {H_IDLE, H_READY, H_WAIT} hs_state_t;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Unmapped codes (and prefixes) map to OP_NONE.
  function automatic operation_t decode_scancode(input logic ext, input logic [7:0] code);
    operation_t op;
    op = OP_NONE;
    if (ext) begin
      case (code)
        SC_UP:    op = OP_W;
        SC_LEFT:  op = OP_A;
        SC_DOWN:  op = OP_S;
        SC_RIGHT: op = OP_D;
        default:  op = OP_NONE;
      endcase
    end else begin
      case (code)
        SC_W:     op = OP_W;
        SC_A:     op = OP_A;
        SC_S:     op = OP_S;
        SC_D:     op = OP_D;
        SC_SPACE: op = OP_SPACE;
        SC_Z:     op = OP_Z;
        default:  op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/keyboard_decoder_if.sv
// Ready/data/read_fin handshake between the keyboard front end and the game logic.
interface keyboard_decoder_if;
  logic       keyboard_ready;
  logic [2:0] keyboard_data;
  logic       keyboard_read_fin;

  modport master (output keyboard_ready, output keyboard_data, input keyboard_read_fin);
  modport slave  (input keyboard_ready, input keyboard_data, output keyboard_read_fin);
endinterface

// File: rtl/ps2_frame_receiver.sv
// Synchronises the raw PS/2 pins, detects falling clock edges and assembles
// 11-bit frames into bytes, flagging parity, stop-bit and inter-edge timeout errors.
module ps2_frame_receiver
  import generals_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int LOG2_TIMEOUT   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_ps2_clock,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_error
);

  logic [1:0]              r_clk_sync;
  logic [1:0]              r_dat_sync;
  logic                    r_clk_prev;
  rx_state_t               r_state;
  logic [2:0]              r_bit_cnt;
  logic [7:0]              r_shift;
  logic                    r_parity;
  logic [LOG2_TIMEOUT-1:0] r_to_cnt;

  logic w_fall;
  logic w_data;
  logic w_timeout;

  assign w_fall    = r_clk_prev & ~r_clk_sync[1];
  assign w_data    = r_dat_sync[1];
  assign w_timeout = (r_state != RX_IDLE) && !w_fall &&
                     (r_to_cnt == LOG2_TIMEOUT'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // Pins idle high, so preload the synchronisers high to avoid a false edge.
      r_clk_sync    <= 2'b11;
      r_dat_sync    <= 2'b11;
      r_clk_prev    <= 1'b1;
      r_state       <= RX_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_to_cnt      <= '0;
      o_byte        <= '0;
      o_byte_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      r_clk_sync    <= {r_clk_sync[0], i_ps2_clock};
      r_dat_sync    <= {r_dat_sync[0], i_ps2_data};
      r_clk_prev    <= r_clk_sync[1];
      o_byte_valid  <= 1'b0;
      o_frame_error <= 1'b0;

      if (w_fall || r_state == RX_IDLE) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + LOG2_TIMEOUT'(1);

      if (w_timeout) begin
        o_frame_error <= 1'b1;
        r_state       <= RX_IDLE;
      end else if (w_fall) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_data) begin
              r_state   <= RX_DATA;
              r_bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            r_shift[r_bit_cnt] <= w_data;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= RX_PARITY;
          end
          RX_PARITY: begin
            r_parity <= w_data;
            r_state  <= RX_STOP;
          end
          RX_STOP: begin
            if ((^{r_shift, r_parity}) && w_data) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
            end else begin
              o_frame_error <= 1'b1;
            end
            r_state <= RX_IDLE;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard front end: scancode-to-operation decode with E0/F0 prefix
// tracking, a one-entry overflow buffer and the 4-phase producer handshake.
module keyboard_decoder
  import generals_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int LOG2_TIMEOUT   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_clock,
  input  logic              ps2_data,
  keyboard_decoder_if.master kb,
  output logic              frame_error,
  output logic [7:0]        drop_count
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_error;
  operation_t w_op;
  logic       w_op_valid;
  logic       w_is_prefix;

  logic       r_ext;
  logic       r_brk;
  hs_state_t  r_hs_state;
  logic       r_ready;
  operation_t r_data;
  operation_t r_buf;
  logic       r_buf_valid;
  logic [7:0] r_drop_count;

  ps2_frame_receiver #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .LOG2_TIMEOUT   (LOG2_TIMEOUT)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .i_ps2_clock   (ps2_clock),
    .i_ps2_data    (ps2_data),
    .o_byte        (w_byte),
    .o_byte_valid  (w_byte_valid),
    .o_frame_error (w_frame_error)
  );

  assign w_is_prefix = (w_byte == SC_EXT) || (w_byte == SC_BREAK);
  assign w_op        = decode_scancode(r_ext, w_byte);
  assign w_op_valid  = w_byte_valid && !w_is_prefix && !r_brk && (w_op != OP_NONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_frame_error) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == SC_BREAK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hs_state   <= H_IDLE;
      r_ready      <= 1'b0;
      r_data       <= OP_NONE;
      r_buf        <= OP_NONE;
      r_buf_valid  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      case (r_hs_state)
        H_IDLE: begin
          if (r_buf_valid) begin
            // Buffered op goes first; a simultaneous decode refills the entry.
            r_data     <= r_buf;
            r_ready    <= 1'b1;
            r_hs_state <= H_READY;
            if (w_op_valid) r_buf <= w_op;
            else            r_buf_valid <= 1'b0;
          end else if (w_op_valid) begin
            r_data     <= w_op;
            r_ready    <= 1'b1;
            r_hs_state <= H_READY;
          end
        end
        H_READY: begin
          if (kb.keyboard_read_fin) begin
            r_ready    <= 1'b0;
            r_hs_state <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (!kb.keyboard_read_fin) r_hs_state <= H_IDLE;
        end
        default: r_hs_state <= H_IDLE;
      endcase

      if (r_hs_state != H_IDLE && w_op_valid) begin
        if (!r_buf_valid) begin
          r_buf       <= w_op;
          r_buf_valid <= 1'b1;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign kb.keyboard_ready = r_ready;
  assign kb.keyboard_data  = r_data;
  assign frame_error       = w_frame_error;
  assign drop_count        = r_drop_count;

endmodule
